// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between the lamp/demand observation point and traffic_light_monitor.
// master drives the observed lamps and demand; slave is the monitor itself.
interface traffic_light_monitor_if;
    logic       mon_en;
    logic [2:0] lightA;
    logic [2:0] lightB;
    logic       carA;
    logic       carB;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] err_cnt;
    logic [3:0] grn_cnt_a;
    logic [3:0] grn_cnt_b;

    modport master (
        output mon_en, lightA, lightB, carA, carB,
        input  err, err_code, err_cnt, grn_cnt_a, grn_cnt_b
    );

    modport slave (
        input  mon_en, lightA, lightB, carA, carB,
        output err, err_code, err_cnt, grn_cnt_a, grn_cnt_b
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-direction traffic light: flags encoding, conflict, sequence and timing violations.
// Optional demand check (code 6) is compiled in with `define TRAFFIC_MON_DEMAND_CHECK_EN.
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 2,
    parameter int unsigned MAX_YELLOW = 1
) (
    input logic                    clk,
    input logic                    rst,
    traffic_light_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        LT_UNKNOWN = 2'd0,
        LT_RED     = 2'd1,
        LT_YELLOW  = 2'd2,
        LT_GREEN   = 2'd3
    } lamp_e;

    localparam logic [4:0] MIN_GREEN_L  = 5'(MIN_GREEN);
    localparam logic [7:0] MAX_YELLOW_L = 8'(MAX_YELLOW);

    function automatic lamp_e decode(input logic [2:0] lamp);
        case (lamp)
            3'b100:  decode = LT_RED;
            3'b010:  decode = LT_YELLOW;
            3'b001:  decode = LT_GREEN;
            default: decode = LT_UNKNOWN;
        endcase
    endfunction

    function automatic logic seq_ok(input lamp_e from_s, input lamp_e to_s);
        case (from_s)
            LT_GREEN:  seq_ok = (to_s == LT_GREEN) || (to_s == LT_YELLOW);
            // Y->Y is policed by the yellow-duration limit, not as a sequence error.
            LT_YELLOW: seq_ok = (to_s == LT_RED) || (to_s == LT_YELLOW);
            LT_RED:    seq_ok = (to_s == LT_RED) || (to_s == LT_GREEN);
            default:   seq_ok = 1'b1;
        endcase
    endfunction

    lamp_e      trk_q [2];
    lamp_e      trk_d [2];
    logic [3:0] grn_q [2];
    logic [3:0] grn_d [2];
    logic [7:0] yel_q [2];
    logic [7:0] yel_d [2];
    logic       prev_valid_q;
    logic       prev_valid_d;
    logic       err_q;
    logic       err_d;
    logic [2:0] code_q;
    logic [2:0] code_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    logic [2:0] light_s [2];
    lamp_e      cur     [2];
    lamp_e      prev    [2];
    logic       illegal;
    logic [6:1] hit;
    logic [2:0] code_now;

`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
    logic [1:0] car_q;
    logic [1:0] car_d;
`else
    logic unused_car;
    assign unused_car = mon.carA ^ mon.carB;
`endif

    assign light_s[0] = mon.lightA;
    assign light_s[1] = mon.lightB;

    always_comb begin
        trk_d        = trk_q;
        grn_d        = grn_q;
        yel_d        = yel_q;
        prev_valid_d = prev_valid_q;
        err_d        = err_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        hit          = '0;
        code_now     = '0;
        illegal      = 1'b0;
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
        car_d        = car_q;
`endif
        // An invalid previous sample behaves exactly like an unknown lamp state.
        for (int unsigned i = 0; i < 2; i++) begin
            cur[i]  = decode(light_s[i]);
            prev[i] = prev_valid_q ? trk_q[i] : LT_UNKNOWN;
            if (cur[i] == LT_UNKNOWN) begin
                illegal = 1'b1;
            end
        end

        if (mon.mon_en) begin
            prev_valid_d = 1'b1;
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
            car_d        = {mon.carA, mon.carB};
`endif
            hit[1] = illegal;
            hit[2] = (cur[0] != LT_RED) && (cur[1] != LT_RED);

            for (int unsigned i = 0; i < 2; i++) begin
                trk_d[i] = illegal ? LT_UNKNOWN : cur[i];

                if (cur[i] == LT_GREEN) begin
                    if (prev[i] == LT_GREEN) begin
                        grn_d[i] = (grn_q[i] == 4'hF) ? grn_q[i] : grn_q[i] + 4'd1;
                    end else begin
                        grn_d[i] = 4'd1;
                    end
                end else begin
                    grn_d[i] = '0;
                end

                if (cur[i] == LT_YELLOW) begin
                    if (prev[i] == LT_YELLOW) begin
                        yel_d[i] = (yel_q[i] == 8'hFF) ? yel_q[i] : yel_q[i] + 8'd1;
                    end else begin
                        yel_d[i] = 8'd1;
                    end
                end else begin
                    yel_d[i] = '0;
                end

                if (!illegal) begin
                    if ((prev[i] != LT_UNKNOWN) && !seq_ok(prev[i], cur[i])) begin
                        hit[3] = 1'b1;
                    end
                    if ((prev[i] == LT_GREEN) && (cur[i] == LT_YELLOW) &&
                        ({1'b0, grn_q[i]} < MIN_GREEN_L)) begin
                        hit[4] = 1'b1;
                    end
                    if (yel_d[i] > MAX_YELLOW_L) begin
                        hit[5] = 1'b1;
                    end
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
                    if ((prev[i] == LT_GREEN) && (cur[i] == LT_YELLOW) &&
                        (car_q != ((i == 0) ? 2'b01 : 2'b10))) begin
                        hit[6] = 1'b1;
                    end
`endif
                end
            end

            if      (hit[1]) code_now = 3'd1;
            else if (hit[2]) code_now = 3'd2;
            else if (hit[3]) code_now = 3'd3;
            else if (hit[4]) code_now = 3'd4;
            else if (hit[5]) code_now = 3'd5;
            else if (hit[6]) code_now = 3'd6;

            if (code_now != '0) begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (!err_q) begin
                    err_d  = 1'b1;
                    code_d = code_now;
                end
            end
        end else begin
            prev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                trk_q[i] <= LT_UNKNOWN;
                grn_q[i] <= '0;
                yel_q[i] <= '0;
            end
            prev_valid_q <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
            cnt_q        <= '0;
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
            car_q        <= '0;
`endif
        end else begin
            trk_q        <= trk_d;
            grn_q        <= grn_d;
            yel_q        <= yel_d;
            prev_valid_q <= prev_valid_d;
            err_q        <= err_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
            car_q        <= car_d;
`endif
        end
    end

    assign mon.err       = err_q;
    assign mon.err_code  = code_q;
    assign mon.err_cnt   = cnt_q;
    assign mon.grn_cnt_a = grn_q[0];
    assign mon.grn_cnt_b = grn_q[1];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized
// lamp sequences compared against a rule-level reference model.
module tb_traffic_light_monitor;
    localparam int unsigned MIN_G = 2;
    localparam int unsigned MAX_Y = 1;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    traffic_light_monitor_if bus();

    traffic_light_monitor #(.MIN_GREEN(MIN_G), .MAX_YELLOW(MAX_Y)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    always #5 clk = ~clk;

    // Reference model: lamp letters 'R','Y','G', '?' for unknown.
    byte     m_last [2];
    bit      m_pv;
    int      m_run_g [2];
    int      m_run_y [2];
    bit      m_err;
    int      m_code;
    int      m_cnt;
    bit [1:0] m_car;

    function automatic byte lamp(input logic [2:0] l);
        case (l)
            3'b100:  return "R";
            3'b010:  return "Y";
            3'b001:  return "G";
            default: return "?";
        endcase
    endfunction

    function automatic bit legal_move(input byte p, input byte c);
        return ({p, c} inside {"GG", "GY", "YR", "YY", "RR", "RG"});
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = "?"; m_run_g[i] = 0; m_run_y[i] = 0;
        end
        m_pv = 0; m_err = 0; m_code = 0; m_cnt = 0; m_car = 2'b00;
    endfunction

    function automatic void model_step(input logic [2:0] a, input logic [2:0] b,
                                       input bit ca, input bit cb, input bit en);
        byte c [2];
        byte p [2];
        bit [6:1] hit;
        bit bad;
        int old_g;
        int first;
        if (!en) begin
            m_pv = 0;
            return;
        end
        c[0] = lamp(a);
        c[1] = lamp(b);
        bad = (c[0] == "?") || (c[1] == "?");
        hit = '0;
        hit[1] = bad;
        hit[2] = (c[0] != "R") && (c[1] != "R");
        for (int i = 0; i < 2; i++) begin
            p[i] = m_pv ? m_last[i] : "?";
            old_g = m_run_g[i];
            m_run_g[i] = (c[i] == "G") ? ((p[i] == "G") ? m_run_g[i] + 1 : 1) : 0;
            m_run_y[i] = (c[i] == "Y") ? ((p[i] == "Y") ? m_run_y[i] + 1 : 1) : 0;
            if (!bad) begin
                if (p[i] != "?" && !legal_move(p[i], c[i])) hit[3] = 1;
                if (p[i] == "G" && c[i] == "Y" && old_g < int'(MIN_G)) hit[4] = 1;
                if (m_run_y[i] > int'(MAX_Y)) hit[5] = 1;
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
                if (p[i] == "G" && c[i] == "Y" && m_car != ((i == 0) ? 2'b01 : 2'b10)) hit[6] = 1;
`endif
            end
            m_last[i] = bad ? "?" : c[i];
        end
        m_car = {ca, cb};
        m_pv = 1;
        first = 0;
        for (int k = 6; k >= 1; k--) if (hit[k]) first = k;
        if (first != 0) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (!m_err) begin
                m_err = 1;
                m_code = first;
            end
        end
    endfunction

    task automatic step(input logic [2:0] a, input logic [2:0] b,
                        input bit ca, input bit cb, input bit en);
        @(negedge clk);
        bus.lightA = a;
        bus.lightB = b;
        bus.carA   = ca;
        bus.carB   = cb;
        bus.mon_en = en;
        model_step(a, b, ca, cb, en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.mon_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mon_en = 1'b0;
        bus.lightA = R; bus.lightB = R; bus.carA = 1'b0; bus.carB = 1'b0;
        model_reset();
        #2;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
        checks++; if (bus.err_code !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", bus.err_code); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.err_cnt); end
        checks++; if (bus.grn_cnt_a !== 4'd0 || bus.grn_cnt_b !== 4'd0) begin
            errors++; $display("FAIL reset_grn got=%0d/%0d exp=0/0", bus.grn_cnt_a, bus.grn_cnt_b);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_legal_run();
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            step(G, R, 1'b0, 1'b1, 1'b1);
            checks++; if (bus.grn_cnt_a !== 4'(n)) begin errors++; $display("FAIL legal_grn_a n=%0d got=%0d exp=%0d", n, bus.grn_cnt_a, n); end
        end
        step(Y, R, 1'b0, 1'b1, 1'b1);
        checks++; if (bus.grn_cnt_a !== 4'd0) begin errors++; $display("FAIL legal_grn_a_yel got=%0d exp=0", bus.grn_cnt_a); end
        step(R, G, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.grn_cnt_b !== 4'd1) begin errors++; $display("FAIL legal_grn_b got=%0d exp=1", bus.grn_cnt_b); end
        checks++; if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL legal_clean got err=%0b cnt=%0d exp err=0 cnt=0", bus.err, bus.err_cnt);
        end
    endtask

    task automatic test_short_green();
        do_reset();
        step(G, R, 1'b0, 1'b0, 1'b1);
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd4 || bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL short_green got err=%0b code=%0d cnt=%0d exp 1/4/1", bus.err, bus.err_code, bus.err_cnt);
        end
    endtask

    task automatic test_conflict_encoding();
        do_reset();
        step(3'b001, 3'b011, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_code !== 3'd1 || bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL enc_first got code=%0d cnt=%0d exp 1/1", bus.err_code, bus.err_cnt);
        end
        step(3'b001, 3'b010, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_code !== 3'd1 || bus.err_cnt !== 8'd2) begin
            errors++; $display("FAIL conflict_sticky got code=%0d cnt=%0d exp 1/2", bus.err_code, bus.err_cnt);
        end
    endtask

    task automatic test_long_yellow_bad_seq();
        do_reset();
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL yel_once got err=%0b exp=0", bus.err); end
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_code !== 3'd5) begin errors++; $display("FAIL long_yellow got=%0d exp=5", bus.err_code); end
        do_reset();
        step(R, R, 1'b0, 1'b0, 1'b1);
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_code !== 3'd3 || bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL bad_seq got code=%0d cnt=%0d exp 3/1", bus.err_code, bus.err_cnt);
        end
    endtask

    task automatic test_demand();
        do_reset();
        step(G, R, 1'b0, 1'b0, 1'b1);
        step(G, R, 1'b0, 1'b0, 1'b1);
        step(Y, R, 1'b0, 1'b0, 1'b1);
`ifdef TRAFFIC_MON_DEMAND_CHECK_EN
        checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd6) begin
            errors++; $display("FAIL demand got err=%0b code=%0d exp 1/6", bus.err, bus.err_code);
        end
`else
        checks++; if (bus.err !== 1'b0 || bus.err_code !== 3'd0) begin
            errors++; $display("FAIL demand_off got err=%0b code=%0d exp 0/0", bus.err, bus.err_code);
        end
`endif
    endtask

    task automatic test_enable_freeze();
        do_reset();
        step(G, R, 1'b0, 1'b1, 1'b1);
        step(G, R, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(3'b111, 3'b111, 1'b1, 1'b1, 1'b0);
            checks++; if (bus.err !== 1'b0 || bus.grn_cnt_a !== 4'd2) begin
                errors++; $display("FAIL freeze n=%0d got err=%0b grn_a=%0d exp 0/2", n, bus.err, bus.grn_cnt_a);
            end
        end
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err !== 1'b0 || bus.grn_cnt_a !== 4'd0) begin
            errors++; $display("FAIL resume_unchecked got err=%0b grn_a=%0d exp 0/0", bus.err, bus.grn_cnt_a);
        end
        step(Y, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_code !== 3'd5) begin errors++; $display("FAIL resume_long_yellow got=%0d exp=5", bus.err_code); end
    endtask

    task automatic test_random();
        logic [2:0] a, b;
        bit en;
        for (int round = 0; round < 8; round++) begin
            do_reset();
            for (int cyc = 0; cyc < 40; cyc++) begin
                case ($urandom_range(0, 9))
                    0, 1:    begin a = G; b = R; end
                    2:       begin a = Y; b = R; end
                    3:       begin a = R; b = R; end
                    4, 5:    begin a = R; b = G; end
                    6:       begin a = R; b = Y; end
                    7:       begin a = 3'($urandom_range(0, 7)); b = R; end
                    8:       begin a = G; b = G; end
                    default: begin a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); end
                endcase
                en = ($urandom_range(0, 15) != 0);
                step(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), en);
                checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rand_err r=%0d c=%0d got=%0b exp=%0b", round, cyc, bus.err, m_err); end
                checks++; if (bus.err_code !== 3'(m_code)) begin errors++; $display("FAIL rand_code r=%0d c=%0d got=%0d exp=%0d", round, cyc, bus.err_code, m_code); end
                checks++; if (bus.err_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt r=%0d c=%0d got=%0d exp=%0d", round, cyc, bus.err_cnt, m_cnt); end
                checks++; if (bus.grn_cnt_a !== 4'((m_run_g[0] > 15) ? 15 : m_run_g[0])) begin
                    errors++; $display("FAIL rand_grn_a r=%0d c=%0d got=%0d exp=%0d", round, cyc, bus.grn_cnt_a, m_run_g[0]);
                end
                checks++; if (bus.grn_cnt_b !== 4'((m_run_g[1] > 15) ? 15 : m_run_g[1])) begin
                    errors++; $display("FAIL rand_grn_b r=%0d c=%0d got=%0d exp=%0d", round, cyc, bus.grn_cnt_b, m_run_g[1]);
                end
            end
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int n = 0; n < 300; n++) step(3'b111, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_cnt !== 8'd255 || bus.err_code !== 3'd1) begin
            errors++; $display("FAIL saturate got cnt=%0d code=%0d exp 255/1", bus.err_cnt, bus.err_code);
        end
        for (int n = 0; n < 3; n++) step(G, R, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.err_cnt !== 8'd255 || bus.grn_cnt_a !== 4'd3) begin
            errors++; $display("FAIL saturate_hold got cnt=%0d grn_a=%0d exp 255/3", bus.err_cnt, bus.grn_cnt_a);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.err !== 1'b0 || bus.err_code !== 3'd0 || bus.err_cnt !== 8'd0 ||
                      bus.grn_cnt_a !== 4'd0 || bus.grn_cnt_b !== 4'd0) begin
            errors++; $display("FAIL async_reset got err=%0b code=%0d cnt=%0d grn=%0d/%0d exp all 0",
                               bus.err, bus.err_code, bus.err_cnt, bus.grn_cnt_a, bus.grn_cnt_b);
        end
        @(negedge clk);
        bus.mon_en = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_legal_run();
        test_short_green();
        test_conflict_encoding();
        test_long_yellow_bad_seq();
        test_demand();
        test_enable_freeze();
        test_random();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 2: minimum consecutive GREEN samples before a GREEN->YELLOW transition.
REQ-002 SHALL have parameter MAX_YELLOW, default 1: maximum consecutive YELLOW samples per direction.
REQ-003 SHALL have port clk, input, 1: single clock; all sampling on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port mon_en, input, 1: 1 = checking active; 0 = hold all state, flag nothing.
REQ-006 SHALL have ports lightA and lightB, input, 3 each: observed lamps, one-hot RED=100, YELLOW=010, GREEN=001.
REQ-007 SHALL have ports carA and carB, input, 1 each: vehicle demand seen by the controller.
REQ-008 SHALL have port err, output, 1: sticky; set on the first detected violation.
REQ-009 SHALL have port err_code, output, 3: code of the first violation; 0 = none.
REQ-010 SHALL have port err_cnt, output, 8: count of cycles containing a violation; saturates at 255.
REQ-011 SHALL have ports grn_cnt_a and grn_cnt_b, output, 4 each: current consecutive GREEN run length per direction; saturates at 15.

Function
REQ-012 SHALL sample lightA, lightB, carA and carB every clk edge with mon_en=1; registered outputs update in that same edge (1-cycle latency).
REQ-013 SHALL keep a per-direction state tracker {UNKNOWN, RED, YELLOW, GREEN} holding the previous sample, plus prev_valid, cleared by reset.
REQ-014 SHALL raise code 1 ILLEGAL_ENC when either light is not one of the three legal codes; that cycle skips codes 3-6 and sets the tracker to UNKNOWN.
REQ-015 SHALL raise code 2 CONFLICT when neither light is RED.
REQ-016 SHALL raise code 3 BAD_SEQ when prev_valid=1 and a direction moves other than G->G, G->Y, Y->R, R->R, R->G; UNKNOWN previous state skips this check.
REQ-017 SHALL raise code 4 SHORT_GREEN on G->Y when that direction's previous grn_cnt < MIN_GREEN.
REQ-018 SHALL raise code 5 LONG_YELLOW when a direction has been YELLOW for more than MAX_YELLOW consecutive samples.
REQ-019 SHALL, when several codes hit in one cycle, report the lowest code; err_cnt increments by exactly 1 per cycle.
REQ-020 SHALL latch err_code only when err is 0; later violations increment err_cnt but leave err_code unchanged.
REQ-021 SHALL set grn_cnt_x to 1 on entry to GREEN, increment while GREEN, and clear on any non-GREEN sample.
REQ-022 SHALL, with mon_en=0, freeze trackers, counters and flags; re-enable resumes with prev_valid cleared, so the first sample is not sequence-checked.
REQ-023 SHALL compare against legal two-direction states only; it does not force or drive the lights.

Reset
REQ-024 SHALL, on rst=0 at any time, asynchronously clear err=0, err_code=0, err_cnt=0, grn_cnt_a=0, grn_cnt_b=0, trackers to UNKNOWN and prev_valid=0.
REQ-025 SHALL not sequence-check the first enabled sample after reset release.

Configuration
REQ-026 SHALL, with macro TRAFFIC_MON_DEMAND_CHECK_EN defined, raise code 6 UNREQUESTED when A goes G->Y and the previous sample's {carA,carB} != 01, or B goes G->Y and the previous sample's {carA,carB} != 10.
REQ-027 SHALL, without TRAFFIC_MON_DEMAND_CHECK_EN, never produce code 6; carA and carB are then unused.

Verification
REQ-028 SHALL pass legal run: reset, then A=GRN/B=RED x3 with carB=1, A=YEL x1, A=RED/B=GRN -> err=0, err_cnt=0, grn_cnt_a=3 before YEL, grn_cnt_b=1 after.
REQ-029 SHALL pass short green: A=GRN x1, then A=YEL -> err=1, err_code=4, err_cnt=1.
REQ-030 SHALL pass conflict plus encoding: lightA=001, lightB=011 -> err_code=1; lightB=010 on the next cycle -> err_cnt=2, err_code still 1.
REQ-031 SHALL pass long yellow and bad sequence: A=YEL x2 -> code 5; a fresh run A=RED then A=YEL -> code 3.
REQ-032 SHALL pass saturation and reset: 300 cycles of lightA=111 -> err_cnt=255; rst=0 mid-clock -> all outputs 0 immediately.
REQ-033 SHALL pass demand check: with the macro, A G->Y after {carA,carB}=00 and grn_cnt_a>=2 -> code 6; without the macro -> err=0.
